spi_target_regfile: RTL and testbench
=====================================

Name: spi_target_regfile

Overview:
- SPI mode-0 target (responder) exposing a small byte-addressed register file to an external SPI host, e.g. a second board or a host-side bring-up adapter driving the FPGA pins.
- Counterpart of the SoC SPI host interface (sck / csb / sd, with per-signal enables).
- Runs entirely in the SoC clock domain: SPI pins are 2-FF synchronized and SCK edges are detected by oversampling.
- Local side gives the SoC a combinational read port and a write-notification strobe.

Parameters:
- NumRegs, 16, number of 8-bit registers; must be a power of two, 2..256.
- AddrWidth, $clog2(NumRegs), derived register index width.
- SyncStages, 2, synchronizer depth for sck/csb/sd inputs (≥2).

Ports:
- clk_i  in  1  SoC clock; SCK frequency must be ≤ clk_i/8.
- rst_ni  in  1  asynchronous active-low reset.
- spi_sck_i  in  1  SPI clock from host; idles low (mode 0).
- spi_csb_i  in  1  chip select, active low.
- spi_sd_i  in  1  MOSI.
- spi_sd_o  out  1  MISO.
- spi_sd_en_o  out  1  MISO output enable; pad is tristated when low.
- reg_raddr_i  in  AddrWidth  local read address.
- reg_rdata_o  out  8  combinational read of regs[reg_raddr_i].
- wr_valid_o  out  1  one-cycle pulse on each SPI-initiated register write.
- wr_addr_o  out  AddrWidth  address of that write; valid with wr_valid_o.
- wr_data_o  out  8  data of that write; valid with wr_valid_o.

Behaviour:
- Reset values: all registers 0x00; spi_sd_o=0, spi_sd_en_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0; FSM in IDLE; bit counter 0.
- Synchronization:
  - sck, csb and sd each pass through SyncStages flops.
  - Rise = sync sck 0→1; fall = 1→0; both are evaluated only while synced csb=0.
- Bit order and sampling:
  - MSB first.
  - MOSI is sampled on rise; the MISO shift register updates on fall.
  - A 3-bit counter increments on each rise; a byte completes on the rise that brings the count back to 0.
- Frame format: command byte, then address byte, then data bytes.
  - 0x02 = write.
  - 0x03 = read.
  - Any other command is ignored.
- FSM states: IDLE, CMD, ADDR, WR, RD, DISCARD.
  - IDLE → CMD when synced csb falls; the bit counter clears.
  - CMD, on byte complete:
    - 0x02 or 0x03 → ADDR, with the operation latched.
    - Any other value → DISCARD.
  - ADDR, on byte complete:
    - The pointer is loaded with byte[AddrWidth-1:0]; upper bits are ignored.
    - Write operation → WR.
    - Read operation → RD. On entry the shift register loads regs[pointer], and MSB is driven on the next fall.
  - WR, on each byte complete:
    - regs[pointer] <= byte.
    - wr_valid_o pulses the following clk cycle, with the pointer value and byte on wr_addr_o/wr_data_o.
    - pointer <= pointer+1, wrapping modulo NumRegs.
  - RD, on each byte complete:
    - pointer <= pointer+1 (wraps).
    - The shift register reloads regs[new pointer]; its MSB appears on the next fall.
  - DISCARD: inputs are ignored until csb rises.
  - Any state → IDLE when synced csb rises.
    - A partial byte is dropped: no write and no pointer change.
    - spi_sd_en_o deasserts within 1 clk.
- Output enable: spi_sd_en_o=1 only while in RD with csb low; spi_sd_o is 0 whenever not enabled.
- Register conflicts:
  - A local read of a register written in the same cycle returns the old value; the new value is visible the next cycle.
  - An SPI read of a register the same frame just wrote returns the new value, because the write commits before the reload.
- Reset mid-frame: the FSM returns to IDLE. A frame still in progress after reset is treated as starting mid-stream; the host must toggle csb.
- Latency: the SPI write becomes visible on reg_rdata_o 1 clk after the synced rise that completes the byte (SyncStages+1 clk after the pin edge).

Optional Feature:
- Macro: SPI_TARGET_STATUS_EN.
- When defined:
  - Command 0x05 is legal. It moves CMD → RD without an address byte.
  - It returns an 8-bit status byte, repeated for every following byte: {frame_cnt[6:0], last_frame_aborted}.
  - frame_cnt increments (wrapping) on every csb rise that follows a WR frame with at least one completed data byte.
  - last_frame_aborted is set on a csb rise that interrupts a partial byte; it is cleared on a clean csb rise.
  - Reset values: frame_cnt=0, last_frame_aborted=0.
- When undefined: 0x05 goes to DISCARD like any unknown command; no counter logic is built.

Decomposition:
- Package spi_target_pkg holds:
  - the state enum (state_e);
  - localparams CmdWrite=8'h02, CmdRead=8'h03, CmdStatus=8'h05.
- One sub-module, spi_target_edge_sync: synchronizers plus rise/fall/csb-edge detection. It is instantiated once for sck/csb/sd.

Test Plan:
- Single write: csb low; send 0x02, 0x05, 0xA5; csb high → one wr_valid_o pulse with addr=5, data=0xA5. Then reg_raddr_i=5 gives reg_rdata_o=0xA5.
- Burst write with wrap (NumRegs=16): send 0x02, 0x0F, 0x11, 0x22 → regs[15]=0x11 and regs[0]=0x22, with two pulses in order 15 then 0.
- Burst read: preload regs[3..4]=0x3C,0xC3; send 0x03, 0x03, then clock 16 bits → MISO yields 0x3C then 0xC3. spi_sd_en_o is high only after the address byte and drops within 1 clk of csb rise.
- Abort: send 0x02, 0x01, then 5 bits of a data byte, then csb high → no wr_valid_o and regs[1] unchanged. The next full frame works normally.
- Unknown command: send 0x9F, 0x00, 0xFF → no writes, spi_sd_en_o stays 0, and the next frame works.
- With SPI_TARGET_STATUS_EN: two completed write frames, then one aborted frame, then 0x05 → MISO returns 0x05 ({2,1}). Without the macro, 0x05 returns with spi_sd_en_o=0.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared types and command codes for the SPI target register file.
package spi_target_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WR,
      RD,
      DISCARD
   } state_e;

   localparam logic [7:0] CmdWrite  = 8'h02;
   localparam logic [7:0] CmdRead   = 8'h03;
   localparam logic [7:0] CmdStatus = 8'h05;

endpackage

// File: rtl/spi_target_regfile_if.sv
// SPI pin bundle: the host drives sck/csb/sd_in, the target returns sd_out with its pad enable.
interface spi_target_regfile_if;

   logic sck;
   logic csb;
   logic sd_in;
   logic sd_out;
   logic sd_en;

   modport master (
      output sck,
      output csb,
      output sd_in,
      input  sd_out,
      input  sd_en
   );

   modport slave (
      input  sck,
      input  csb,
      input  sd_in,
      output sd_out,
      output sd_en
   );

endinterface

// File: rtl/spi_target_edge_sync.sv
// Synchronizes sck/csb/sd into clk_i and derives SCK rise/fall (qualified by csb low) and csb edges.
module spi_target_edge_sync #(
   parameter int unsigned SyncStages = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sck_i,
   input  logic csb_i,
   input  logic sd_i,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic csb_rise_o,
   output logic csb_fall_o,
   output logic sd_o
);

   logic [SyncStages-1:0] sck_sync_q;
   logic [SyncStages-1:0] csb_sync_q;
   logic [SyncStages-1:0] sd_sync_q;
   logic                  sck_prev_q;
   logic                  csb_prev_q;
   logic                  sck_s;
   logic                  csb_s;

   // csb resets to the deselected level so an idle bus produces no edge after reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_sync_q <= '0;
         csb_sync_q <= '1;
         sd_sync_q  <= '0;
         sck_prev_q <= 1'b0;
         csb_prev_q <= 1'b1;
      end else begin
         sck_sync_q <= {sck_sync_q[SyncStages-2:0], sck_i};
         csb_sync_q <= {csb_sync_q[SyncStages-2:0], csb_i};
         sd_sync_q  <= {sd_sync_q[SyncStages-2:0], sd_i};
         sck_prev_q <= sck_s;
         csb_prev_q <= csb_s;
      end
   end

   assign sck_s      = sck_sync_q[SyncStages-1];
   assign csb_s      = csb_sync_q[SyncStages-1];
   assign sd_o       = sd_sync_q[SyncStages-1];
   assign sck_rise_o = !csb_s && sck_s && !sck_prev_q;
   assign sck_fall_o = !csb_s && !sck_s && sck_prev_q;
   assign csb_rise_o = csb_s && !csb_prev_q;
   assign csb_fall_o = !csb_s && csb_prev_q;

endmodule

// File: rtl/spi_target_regfile.sv
// SPI mode-0 target exposing an 8-bit register file, fully in the clk_i domain.
// Define SPI_TARGET_STATUS_EN to add command 0x05 returning {frame_cnt[6:0], last_frame_aborted}.
module spi_target_regfile
   import spi_target_pkg::*;
#(
   parameter int unsigned NumRegs    = 16,
   parameter int unsigned AddrWidth  = $clog2(NumRegs),
   parameter int unsigned SyncStages = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   spi_target_regfile_if.slave  spi,
   input  logic [AddrWidth-1:0] reg_raddr_i,
   output logic [7:0]           reg_rdata_o,
   output logic                 wr_valid_o,
   output logic [AddrWidth-1:0] wr_addr_o,
   output logic [7:0]           wr_data_o
);

   logic sck_rise;
   logic sck_fall;
   logic csb_rise;
   logic csb_fall;
   logic sd_sync;

   spi_target_edge_sync #(
      .SyncStages(SyncStages)
   ) u_edge_sync (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .sck_i     (spi.sck),
      .csb_i     (spi.csb),
      .sd_i      (spi.sd_in),
      .sck_rise_o(sck_rise),
      .sck_fall_o(sck_fall),
      .csb_rise_o(csb_rise),
      .csb_fall_o(csb_fall),
      .sd_o      (sd_sync)
   );

   state_e               state_q;
   logic [2:0]           bit_cnt_q;
   logic [6:0]           shift_in_q;
   logic [7:0]           shift_out_q;
   logic [AddrWidth-1:0] ptr_q;
   logic                 op_wr_q;
   logic [7:0]           regs_q [NumRegs];
   logic                 wr_valid_q;
   logic [AddrWidth-1:0] wr_addr_q;
   logic [7:0]           wr_data_q;
   logic                 sd_o_q;
   logic                 sd_en_q;

   logic [7:0]           rx_byte_d;
   logic                 byte_done_d;
   logic [AddrWidth-1:0] addr_d;
   logic [AddrWidth-1:0] ptr_inc_d;
   logic [7:0]           rd_reload_d;

   assign rx_byte_d   = {shift_in_q, sd_sync};
   assign byte_done_d = sck_rise && (bit_cnt_q == 3'd7);
   assign addr_d      = rx_byte_d[AddrWidth-1:0];
   assign ptr_inc_d   = ptr_q + AddrWidth'(1);

`ifdef SPI_TARGET_STATUS_EN
   logic [6:0] frame_cnt_q;
   logic       aborted_q;
   logic       status_q;
   logic       wr_seen_q;
   logic [7:0] status_byte_d;

   assign status_byte_d = {frame_cnt_q, aborted_q};
   assign rd_reload_d   = status_q ? status_byte_d : regs_q[ptr_inc_d];
`else
   assign rd_reload_d   = regs_q[ptr_inc_d];
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         ptr_q       <= '0;
         op_wr_q     <= 1'b0;
         for (int unsigned i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         sd_o_q      <= 1'b0;
         sd_en_q     <= 1'b0;
`ifdef SPI_TARGET_STATUS_EN
         frame_cnt_q <= '0;
         aborted_q   <= 1'b0;
         status_q    <= 1'b0;
         wr_seen_q   <= 1'b0;
`endif
      end else begin
         wr_valid_q <= 1'b0;
         if (csb_rise) begin
            // end of frame: any partial byte is simply forgotten
            state_q <= IDLE;
            sd_en_q <= 1'b0;
            sd_o_q  <= 1'b0;
`ifdef SPI_TARGET_STATUS_EN
            if (state_q == WR && wr_seen_q) begin
               frame_cnt_q <= frame_cnt_q + 7'd1;
            end
            aborted_q <= (bit_cnt_q != 3'd0);
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  if (csb_fall) begin
                     state_q   <= CMD;
                     bit_cnt_q <= '0;
`ifdef SPI_TARGET_STATUS_EN
                     status_q  <= 1'b0;
                     wr_seen_q <= 1'b0;
`endif
                  end
               end
               DISCARD: ;
               default: begin
                  if (sck_rise) begin
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     shift_in_q <= rx_byte_d[6:0];
                  end
                  if (byte_done_d) begin
                     case (state_q)
                        CMD: begin
                           if (rx_byte_d == CmdWrite || rx_byte_d == CmdRead) begin
                              op_wr_q <= (rx_byte_d == CmdWrite);
                              state_q <= ADDR;
`ifdef SPI_TARGET_STATUS_EN
                           end else if (rx_byte_d == CmdStatus) begin
                              status_q    <= 1'b1;
                              state_q     <= RD;
                              sd_en_q     <= 1'b1;
                              shift_out_q <= status_byte_d;
`endif
                           end else begin
                              state_q <= DISCARD;
                           end
                        end
                        ADDR: begin
                           ptr_q       <= addr_d;
                           shift_out_q <= regs_q[addr_d];
                           if (op_wr_q) begin
                              state_q <= WR;
                           end else begin
                              state_q <= RD;
                              sd_en_q <= 1'b1;
                           end
                        end
                        WR: begin
                           regs_q[ptr_q] <= rx_byte_d;
                           wr_valid_q    <= 1'b1;
                           wr_addr_q     <= ptr_q;
                           wr_data_q     <= rx_byte_d;
                           ptr_q         <= ptr_inc_d;
`ifdef SPI_TARGET_STATUS_EN
                           wr_seen_q     <= 1'b1;
`endif
                        end
                        RD: begin
                           ptr_q       <= ptr_inc_d;
                           shift_out_q <= rd_reload_d;
                        end
                        default: ;
                     endcase
                  end
                  if (sck_fall && state_q == RD) begin
                     sd_o_q      <= shift_out_q[7];
                     shift_out_q <= {shift_out_q[6:0], 1'b0};
                  end
               end
            endcase
         end
      end
   end

   assign reg_rdata_o = regs_q[reg_raddr_i];
   assign wr_valid_o  = wr_valid_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign spi.sd_out  = sd_o_q;
   assign spi.sd_en   = sd_en_q;

endmodule

// File: tb/tb_spi_target_regfile.sv
// Randomised SPI-host bench for spi_target_regfile with a frame-level register/status model.
`timescale 1ns/1ps
module tb_spi_target_regfile;

   localparam int unsigned NumRegs   = 16;
   localparam int unsigned AddrWidth = 4;
   localparam int          Half      = 6;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b0;
   logic [AddrWidth-1:0] raddr = '0;
   logic [7:0]           rdata;
   logic                 wr_valid;
   logic [AddrWidth-1:0] wr_addr;
   logic [7:0]           wr_data;

   spi_target_regfile_if spi_if ();

   spi_target_regfile #(
      .NumRegs   (NumRegs),
      .SyncStages(2)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .spi        (spi_if),
      .reg_raddr_i(raddr),
      .reg_rdata_o(rdata),
      .wr_valid_o (wr_valid),
      .wr_addr_o  (wr_addr),
      .wr_data_o  (wr_data)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   bit          quiet       = 1'b0;
   logic [7:0]  m_regs [NumRegs];
   logic [6:0]  m_cnt;
   logic        m_ab;
   logic [11:0] exp_wr_q [$];
   logic [11:0] obs_q [$];
   logic [7:0]  tx_buf [16];
   logic [7:0]  rx_buf [16];
   bit          en_all [16];
   bit          en_any [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: write pulses against the expected-write queue, MISO idle level, and local reads when the bus is quiet.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_valid) begin
            obs_q.push_back({wr_addr, wr_data});
            if (exp_wr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write", wr_addr, wr_data);
            end else begin
               chk("wr_pulse", 32'({wr_addr, wr_data}), 32'(exp_wr_q.pop_front()));
            end
         end
         if (!spi_if.sd_en) chk("miso_idle", 32'(spi_if.sd_out), 32'd0);
         if (quiet) begin
            chk("rdata", 32'(rdata), 32'(m_regs[raddr]));
            chk("en_quiet", 32'(spi_if.sd_en), 32'd0);
         end
      end
   end

   task automatic do_reset();
      rst_n        = 1'b0;
      spi_if.csb   = 1'b1;
      spi_if.sck   = 1'b0;
      spi_if.sd_in = 1'b0;
      raddr        = '0;
      for (int i = 0; i < NumRegs; i++) m_regs[i] = '0;
      m_cnt = '0;
      m_ab  = 1'b0;
      exp_wr_q.delete();
      obs_q.delete();
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(3);
   endtask

   task automatic spi_frame(input int nbits);
      logic [7:0] t;
      for (int i = 0; i < 16; i++) begin
         rx_buf[i] = '0;
         en_all[i] = 1'b1;
         en_any[i] = 1'b0;
      end
      spi_if.csb = 1'b0;
      wait_clk(Half);
      for (int b = 0; b < nbits; b++) begin
         t = tx_buf[b / 8];
         spi_if.sd_in = t[7 - (b % 8)];
         wait_clk(Half);
         rx_buf[b / 8][7 - (b % 8)] = spi_if.sd_out;
         en_all[b / 8] = en_all[b / 8] & spi_if.sd_en;
         en_any[b / 8] = en_any[b / 8] | spi_if.sd_en;
         spi_if.sck = 1'b1;
         wait_clk(Half);
         spi_if.sck = 1'b0;
      end
      wait_clk(Half);
      spi_if.csb = 1'b1;
      wait_clk(4);
      chk("en_drop", 32'(spi_if.sd_en), 32'd0);
      wait_clk(8);
   endtask

   // Frame-level model: decide what the frame means from its bytes, then check what the host saw.
   task automatic run_frame(input int nbits);
      int                   full;
      int                   nb_any;
      logic [7:0]           cmd;
      logic [7:0]           st;
      logic [7:0]           exp_rx [16];
      logic [AddrWidth-1:0] a;
      bit                   is_wr, is_rd, is_st, disc;
      full   = nbits / 8;
      nb_any = (nbits + 7) / 8;
      cmd    = tx_buf[0];
      is_wr  = (full >= 1) && (cmd == 8'h02);
      is_rd  = (full >= 1) && (cmd == 8'h03);
`ifdef SPI_TARGET_STATUS_EN
      is_st  = (full >= 1) && (cmd == 8'h05);
`else
      is_st  = 1'b0;
`endif
      disc   = (full >= 1) && !(is_wr || is_rd || is_st);
      st     = {m_cnt, m_ab};
      a      = tx_buf[1][AddrWidth-1:0];
      for (int k = 0; k < 16; k++) exp_rx[k] = '0;
      if (is_wr) begin
         for (int k = 2; k < full; k++) begin
            exp_wr_q.push_back({a, tx_buf[k]});
            m_regs[a] = tx_buf[k];
            a = a + 1'b1;
         end
      end
      if (is_rd) begin
         for (int k = 2; k < full; k++) begin
            exp_rx[k] = m_regs[a];
            a = a + 1'b1;
         end
      end
      if (is_st) begin
         for (int k = 1; k < full; k++) exp_rx[k] = st;
      end
      spi_frame(nbits);
      for (int k = 0; k < nb_any; k++) begin
         if ((is_rd && k >= 2 && k < full) || (is_st && k >= 1 && k < full)) begin
            chk("rd_data", 32'(rx_buf[k]), 32'(exp_rx[k]));
            chk("rd_en", 32'(en_all[k]), 32'd1);
         end else if (!(is_rd && k >= 2) && !(is_st && k >= 1)) begin
            chk("en_off", 32'(en_any[k]), 32'd0);
         end
      end
      if (is_wr && full >= 3) m_cnt = m_cnt + 1'b1;
      m_ab = !disc && ((nbits % 8) != 0);
   endtask

   task automatic settle();
      quiet = 1'b1;
      repeat (12) begin
         raddr = AddrWidth'($urandom_range(0, NumRegs - 1));
         wait_clk(1);
      end
      quiet = 1'b0;
      vectors++;
      if (exp_wr_q.size() != 0) begin
         miscompares++;
         $display("FAIL wr_missing: %0d writes pending, expected 0", exp_wr_q.size());
         exp_wr_q.delete();
      end
   endtask

   task automatic peek(input int addr, input logic [7:0] exp, input string name);
      raddr = AddrWidth'(addr);
      #1;
      chk(name, 32'(rdata), 32'(exp));
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16; i++) tx_buf[i] = 8'($urandom);
   endtask

   initial begin
      int         kind;
      int         nbits;
      logic [7:0] cmd;
      do_reset();
      chk("rst_sd_o", 32'(spi_if.sd_out), 32'd0);
      chk("rst_sd_en", 32'(spi_if.sd_en), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      for (int i = 0; i < NumRegs; i++) peek(i, 8'h00, "rst_reg");

      // single write
      fill_random();
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h05; tx_buf[2] = 8'hA5;
      obs_q.delete();
      run_frame(24);
      settle();
      chk("sw_count", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() == 1) chk("sw_pulse", 32'(obs_q[0]), 32'h5A5);
      peek(5, 8'hA5, "sw_rdata");

      // burst write wrapping 15 -> 0
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h0F; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22;
      obs_q.delete();
      run_frame(32);
      settle();
      chk("wrap_count", 32'(obs_q.size()), 32'd2);
      if (obs_q.size() == 2) begin
         chk("wrap_pulse0", 32'(obs_q[0]), 32'hF11);
         chk("wrap_pulse1", 32'(obs_q[1]), 32'h022);
      end
      peek(15, 8'h11, "wrap_reg15");
      peek(0, 8'h22, "wrap_reg0");

      // burst read of 3..4
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h03; tx_buf[2] = 8'h3C; tx_buf[3] = 8'hC3;
      run_frame(32);
      settle();
      tx_buf[0] = 8'h03; tx_buf[1] = 8'h03; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      run_frame(32);
      settle();
      chk("br_byte0", 32'(rx_buf[2]), 32'h3C);
      chk("br_byte1", 32'(rx_buf[3]), 32'hC3);
      chk("br_en_addr", 32'(en_any[1]), 32'd0);

      // aborted data byte
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h01; tx_buf[2] = 8'hFF;
      obs_q.delete();
      run_frame(21);
      settle();
      chk("abort_count", 32'(obs_q.size()), 32'd0);
      peek(1, 8'h00, "abort_reg1");
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h01; tx_buf[2] = 8'h77;
      run_frame(24);
      settle();
      peek(1, 8'h77, "after_abort_reg1");

      // unknown command
      tx_buf[0] = 8'h9F; tx_buf[1] = 8'h00; tx_buf[2] = 8'hFF;
      obs_q.delete();
      run_frame(24);
      settle();
      chk("unk_count", 32'(obs_q.size()), 32'd0);
      chk("unk_en", 32'(en_any[2]), 32'd0);
      tx_buf[0] = 8'h03; tx_buf[1] = 8'h05; tx_buf[2] = 8'h00;
      run_frame(24);
      settle();
      chk("unk_next", 32'(rx_buf[2]), 32'hA5);

      // status: two writes, one abort, then 0x05
      do_reset();
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h01;
      run_frame(24);
      settle();
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h01; tx_buf[2] = 8'h02;
      run_frame(24);
      settle();
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h02; tx_buf[2] = 8'hFF;
      run_frame(20);
      settle();
      tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
      run_frame(24);
      settle();
`ifdef SPI_TARGET_STATUS_EN
      chk("status_byte0", 32'(rx_buf[1]), 32'h05);
      chk("status_byte1", 32'(rx_buf[2]), 32'h05);
`else
      chk("status_off_en", 32'(en_any[1]), 32'd0);
      chk("status_off_miso", 32'(rx_buf[1]), 32'h00);
`endif

      // randomised frames
      for (int f = 0; f < 60; f++) begin
         fill_random();
         kind = $urandom_range(0, 5);
         case (kind)
            0: begin tx_buf[0] = 8'h02; nbits = 8 * $urandom_range(3, 7); end
            1: begin tx_buf[0] = 8'h03; nbits = 8 * $urandom_range(3, 6); end
            2: begin
               tx_buf[0] = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h03;
               nbits = $urandom_range(1, 39);
               if ((nbits % 8) == 0) nbits++;
            end
            3: begin
               cmd = 8'($urandom);
               while (cmd == 8'h02 || cmd == 8'h03 || cmd == 8'h05) cmd = 8'($urandom);
               tx_buf[0] = cmd;
               nbits = 8 * $urandom_range(1, 4);
            end
            4: begin tx_buf[0] = 8'h05; nbits = $urandom_range(8, 30); end
            default: nbits = $urandom_range(0, 7);
         endcase
         run_frame(nbits);
         settle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
